// File: rtl/data_mem_pkg.sv
// data_mem_pkg
//   Shared types and constants for the data memory port: the arbitration FSM
//   state encoding, host transfer direction codes and the default depth.
package data_mem_pkg;

  localparam int DEFAULT_MEM_DEPTH = 1024;

  localparam logic DIR_LOAD = 1'b0;  // host writes memory
  localparam logic DIR_DUMP = 1'b1;  // host reads memory

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DUMP_RD,
    ST_DUMP_HOLD,
    ST_DONE
  } dmp_state_t;

endpackage

// File: rtl/sync_ram_1rw.sv
// sync_ram_1rw
//   Single-port DEPTH x 8 synchronous RAM with a registered, read-before-write
//   read port. The read register only updates when i_en is high, so the last
//   read byte is held for as long as the caller needs it.
// Ports:
//   i_clk, i_rst  clock, async active-high reset (read register only)
//   i_en          load the read register with mem[i_addr]
//   i_we          write i_wdata to mem[i_addr]
//   i_addr        word address
//   i_wdata       write byte
//   o_rdata       registered read byte
module sync_ram_1rw
  import data_mem_pkg::*;
#(
  parameter int DEPTH = DEFAULT_MEM_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_wdata,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rdata;

  // NOTE: the array has no reset on purpose -- contents must survive rst, and
  // a reset on a memory prevents mapping it onto RAM macros.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  // NOTE: non-blocking assignment is what gives read-before-write here: the
  // read samples the array before this edge's write lands.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     r_rdata <= '0;
    else if (i_en) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_port.sv
// data_mem_port
//   Byte-wide data memory serving the processor port (addr/to_mem/dm_wr ->
//   dm_out) and a host bulk-transfer port (valid/ready load and dump streams).
//   An FSM hands the single RAM port to the host while a transfer is active;
//   during that time processor writes are dropped and dm_out holds.
// Ports:
//   clk, rst                       clock, async active-high reset
//   addr, to_mem, dm_wr            processor address, write data, write strobe
//   dm_out                         registered processor read data
//   addr_err                       sticky out-of-range processor access flag
//   host_start/dir/base/len        transfer command (accepted in IDLE only)
//   host_wdata/wvalid/wready       load stream
//   host_rdata/rvalid/rready       dump stream
//   busy, done                     FSM not idle / end-of-transfer pulse
module data_mem_port
  import data_mem_pkg::*;
#(
  parameter int MEM_DEPTH  = DEFAULT_MEM_DEPTH,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [15:0]           to_mem,
  input  logic                  dm_wr,
  output logic [7:0]            dm_out,
  output logic                  addr_err,
  input  logic                  host_start,
  input  logic                  host_dir,
  input  logic [ADDR_WIDTH-1:0] host_base,
  input  logic [LEN_WIDTH-1:0]  host_len,
  input  logic [7:0]            host_wdata,
  input  logic                  host_wvalid,
  output logic                  host_wready,
  output logic [7:0]            host_rdata,
  output logic                  host_rvalid,
  input  logic                  host_rready,
  output logic                  busy,
  output logic                  done
);

  localparam int RAM_AW = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_LIMIT = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [RAM_AW-1:0]     PTR_LAST    = RAM_AW'(MEM_DEPTH - 1);
  localparam logic [LEN_WIDTH-1:0]  CNT_LAST    = LEN_WIDTH'(1);

  dmp_state_t          r_state, w_state_next;
  logic [RAM_AW-1:0]   r_ptr;
  logic [LEN_WIDTH-1:0] r_cnt;
  logic                r_proc_sel;   // RAM read register holds a processor read
  logic                r_proc_oor;   // that processor read was out of range
  logic [7:0]          r_dm_hold;
  logic                r_addr_err;

  logic                w_oor;
  logic                w_ram_en, w_ram_we;
  logic [RAM_AW-1:0]   w_ram_addr;
  logic [7:0]          w_ram_wdata, w_ram_rdata;
  logic                w_start, w_ptr_inc, w_cnt_dec;
  logic [7:0]          w_dm_out;
  logic                w_unused;

  // Upper data bits are not stored; base is reduced modulo MEM_DEPTH by
  // truncation, so MEM_DEPTH is expected to be a power of two.
  assign w_unused = ^{to_mem[15:8], host_base[ADDR_WIDTH-1:RAM_AW]};

  assign w_oor = (addr >= DEPTH_LIMIT);

  sync_ram_1rw #(.DEPTH(MEM_DEPTH), .AW(RAM_AW)) u_ram (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_en    (w_ram_en),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // NOTE: every signal gets a default first so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_ram_en     = 1'b0;
    w_ram_we     = 1'b0;
    w_ram_addr   = r_ptr;
    w_ram_wdata  = host_wdata;
    w_start      = 1'b0;
    w_ptr_inc    = 1'b0;
    w_cnt_dec    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ram_en    = 1'b1;
        w_ram_addr  = addr[RAM_AW-1:0];
        w_ram_wdata = to_mem[7:0];
        w_ram_we    = dm_wr & ~w_oor;
        if (host_start) begin
          w_start = 1'b1;
          if (host_len == '0)          w_state_next = ST_DONE;
          else if (host_dir == DIR_DUMP) w_state_next = ST_DUMP_RD;
          else                         w_state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (host_wvalid) begin
          w_ram_we  = 1'b1;
          w_ptr_inc = 1'b1;
          w_cnt_dec = 1'b1;
          if (r_cnt == CNT_LAST) w_state_next = ST_DONE;
        end
      end
      ST_DUMP_RD: begin
        w_ram_en     = 1'b1;
        w_ptr_inc    = 1'b1;
        w_state_next = ST_DUMP_HOLD;
      end
      ST_DUMP_HOLD: begin
        // RAM read register is not enabled here, so host_rdata stays stable.
        if (host_rready) begin
          w_cnt_dec    = 1'b1;
          w_state_next = (r_cnt == CNT_LAST) ? ST_DONE : ST_DUMP_RD;
        end
      end
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (w_start) begin
      r_ptr <= host_base[RAM_AW-1:0];
      r_cnt <= host_len;
    end else begin
      if (w_ptr_inc) r_ptr <= (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;
      if (w_cnt_dec) r_cnt <= r_cnt - 1'b1;
    end
  end

  // The RAM read register is shared with the dump path, so dm_out shows it
  // only when it was loaded by a processor read; otherwise the previous
  // dm_out is replayed from r_dm_hold.
  assign w_dm_out = r_proc_sel ? (r_proc_oor ? 8'h00 : w_ram_rdata) : r_dm_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_proc_sel <= 1'b0;
      r_proc_oor <= 1'b0;
      r_dm_hold  <= '0;
      r_addr_err <= 1'b0;
    end else begin
      r_proc_sel <= (r_state == ST_IDLE);
      r_proc_oor <= w_oor;
      r_dm_hold  <= w_dm_out;
      if (r_state == ST_IDLE && w_oor) r_addr_err <= 1'b1;
    end
  end

  assign dm_out      = w_dm_out;
  assign addr_err    = r_addr_err;
  assign host_wready = (r_state == ST_LOAD);
  assign host_rvalid = (r_state == ST_DUMP_HOLD);
  assign host_rdata  = host_rvalid ? w_ram_rdata : 8'h00;
  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_DONE);

endmodule

// File: tb/tb_data_mem_port.sv
module tb_data_mem_port;
  import data_mem_pkg::*;

  logic        clk, rst;
  logic [15:0] addr, to_mem;
  logic        dm_wr;
  logic [7:0]  dm_out;
  logic        addr_err;
  logic        host_start, host_dir;
  logic [15:0] host_base, host_len;
  logic [7:0]  host_wdata, host_rdata;
  logic        host_wvalid, host_wready, host_rvalid, host_rready;
  logic        busy, done;

  data_mem_port dut (
    .clk(clk), .rst(rst), .addr(addr), .to_mem(to_mem), .dm_wr(dm_wr),
    .dm_out(dm_out), .addr_err(addr_err),
    .host_start(host_start), .host_dir(host_dir), .host_base(host_base),
    .host_len(host_len), .host_wdata(host_wdata), .host_wvalid(host_wvalid),
    .host_wready(host_wready), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid), .host_rready(host_rready),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic        wr;
    logic        chk;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   beat, n_done, stall, busy_bad;
    logic hs;

    // processor vectors: dm_out is checked after the edge that samples them
    vecs[0] = '{16'h0010, 16'h0011, 1'b1, 1'b0, 8'h00};
    vecs[1] = '{16'h0010, 16'h00A5, 1'b1, 1'b1, 8'h11};  // read-before-write
    vecs[2] = '{16'h0010, 16'h0000, 1'b0, 1'b1, 8'hA5};
    vecs[3] = '{16'h0011, 16'h12A5, 1'b1, 1'b0, 8'h00};
    vecs[4] = '{16'h0011, 16'h0000, 1'b0, 1'b1, 8'hA5};  // upper byte dropped
    vecs[5] = '{16'h0012, 16'h00C3, 1'b1, 1'b0, 8'h00};
    vecs[6] = '{16'h0012, 16'h0000, 1'b0, 1'b1, 8'hC3};
    vecs[7] = '{16'h0010, 16'h00FF, 1'b0, 1'b1, 8'hA5};  // no strobe, no write
    vecs[8] = '{16'h0010, 16'h0000, 1'b0, 1'b1, 8'hA5};
    vecs[9] = '{16'h0011, 16'h0000, 1'b0, 1'b1, 8'hA5};

    rst = 1'b1; addr = '0; to_mem = '0; dm_wr = 1'b0;
    host_start = 1'b0; host_dir = DIR_LOAD; host_base = '0; host_len = '0;
    host_wdata = '0; host_wvalid = 1'b0; host_rready = 1'b0;
    #22;
    check("rst_dm_out", dm_out, 8'h00);
    check("rst_addr_err", addr_err, 1'b0);
    check("rst_wready", host_wready, 1'b0);
    check("rst_rvalid", host_rvalid, 1'b0);
    check("rst_rdata", host_rdata, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rst = 1'b0;
    step();

    foreach (vecs[i]) begin
      addr = vecs[i].addr; to_mem = vecs[i].data; dm_wr = vecs[i].wr;
      step();
      if (vecs[i].chk) check($sformatf("vec%0d_dm_out", i), dm_out, vecs[i].exp);
    end
    dm_wr = 1'b0;

    // load 0x20..0x23 with gapped valid, processor write attempts during it
    addr = 16'h0010; host_base = 16'h0020; host_len = 16'd4; host_dir = DIR_LOAD;
    host_start = 1'b1;
    step();
    host_start = 1'b0;
    check("load_busy", busy, 1'b1);
    check("load_wready", host_wready, 1'b1);
    beat = 0; n_done = 0;
    addr = 16'h0022; to_mem = 16'h00EE; dm_wr = 1'b1;
    for (int c = 0; c < 30; c++) begin
      host_wvalid = (c % 2 == 0) && (beat < 4);
      host_wdata  = 8'(beat + 1);
      host_start  = (c == 1);  // must be ignored outside IDLE
      hs = host_wvalid && host_wready;
      step();
      if (hs) beat++;
      if (done) begin
        n_done++;
        check("load_dm_out_hold", dm_out, 8'hA5);
      end
      if (!busy) break;
    end
    host_wvalid = 1'b0; dm_wr = 1'b0; host_start = 1'b0;
    check("load_beats", beat, 4);
    check("load_done_pulses", n_done, 1);
    for (int i = 0; i < 4; i++) begin
      addr = 16'h0020 + 16'(i);
      step();
      check($sformatf("load_rd%0d", i), dm_out, 8'(i + 1));
    end

    // dump 0x20..0x23 with a 3-cycle stall on the second beat
    host_dir = DIR_DUMP; host_start = 1'b1;
    step();
    host_start = 1'b0;
    check("dump_rvalid_early", host_rvalid, 1'b0);
    step();
    check("dump_rvalid_first", host_rvalid, 1'b1);
    beat = 0; stall = 0; busy_bad = 0;
    for (int c = 0; c < 40 && beat < 4; c++) begin
      if (beat == 1 && stall > 0) check("dump_stall_rvalid", host_rvalid, 1'b1);
      if (host_rvalid) begin
        check($sformatf("dump_rdata_b%0d", beat), host_rdata, 8'(beat + 1));
        if (beat == 1 && stall < 3) begin
          host_rready = 1'b0;
          stall++;
        end else host_rready = 1'b1;
      end else host_rready = 1'b0;
      if (busy !== 1'b1) busy_bad++;
      hs = host_rvalid && host_rready;
      step();
      if (hs) beat++;
    end
    host_rready = 1'b0;
    check("dump_beats", beat, 4);
    check("dump_busy_high", busy_bad, 0);
    check("dump_done", done, 1'b1);
    check("dump_done_busy", busy, 1'b1);
    step();
    check("dump_done_fall", done, 1'b0);
    check("dump_busy_fall", busy, 1'b0);

    // zero-length transfer goes straight to DONE
    host_len = 16'd0; host_start = 1'b1;
    step();
    host_start = 1'b0;
    check("zero_done", done, 1'b1);
    check("zero_rvalid", host_rvalid, 1'b0);
    step();
    check("zero_idle", busy, 1'b0);

    // load wrapping past the top of memory
    host_dir = DIR_LOAD; host_base = 16'h03FF; host_len = 16'd2; host_start = 1'b1;
    step();
    host_start = 1'b0;
    host_wvalid = 1'b1; host_wdata = 8'h5E;
    step();
    host_wdata = 8'h6F;
    step();
    host_wvalid = 1'b0;
    check("wrap_done", done, 1'b1);
    step();
    addr = 16'h03FF;
    step();
    check("wrap_rd_3ff", dm_out, 8'h5E);
    addr = 16'h0000;
    step();
    check("wrap_rd_000", dm_out, 8'h6F);
    check("wrap_addr_err", addr_err, 1'b0);

    // out-of-range processor write/read
    addr = 16'h0400; to_mem = 16'h0077; dm_wr = 1'b1;
    step();
    dm_wr = 1'b0;
    check("oor_rd", dm_out, 8'h00);
    check("oor_err", addr_err, 1'b1);
    addr = 16'h0000;
    step();
    check("oor_no_alias", dm_out, 8'h6F);
    step();
    check("oor_err_sticky", addr_err, 1'b1);

    // reset in the middle of a 4-byte load after 2 beats
    host_base = 16'h0030; host_len = 16'd4; host_start = 1'b1;
    step();
    host_start = 1'b0;
    addr = 16'h0031; to_mem = 16'h00EE; dm_wr = 1'b1;
    host_wvalid = 1'b1; host_wdata = 8'hB1;
    step();
    host_wdata = 8'hB2;
    step();
    #2 rst = 1'b1;
    #1;
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_wready", host_wready, 1'b0);
    check("rst_mid_err", addr_err, 1'b0);
    host_wvalid = 1'b0; dm_wr = 1'b0;
    #10 rst = 1'b0;
    n_done = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (done) n_done++;
    end
    check("rst_mid_no_done", n_done, 0);
    addr = 16'h0030;
    step();
    check("rst_mid_rd30", dm_out, 8'hB1);
    addr = 16'h0031;
    step();
    check("rst_mid_rd31", dm_out, 8'hB2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
